// File: rtl/counter60_bcd.sv
// counter60_bcd: synchronises a slow divider tap, turns each rising edge into a tick and
// counts ticks up/down in two-digit BCD modulo MODULUS. Define COUNTER60_SEG7_EN for 7-segment outputs.
module counter60_bcd #(
  parameter int unsigned MODULUS     = 60,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       tick_src,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] ld_tens,
  input  logic [3:0] ld_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry,
`ifdef COUNTER60_SEG7_EN
  output logic       load_err,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones
`else
  output logic       load_err
`endif
);

  localparam logic [3:0] MAX_TENS  = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] MAX_ONES  = 4'((MODULUS - 1) % 10);
  localparam logic [7:0] MOD8      = 8'(MODULUS);
  localparam logic [2:0] FILL_DONE = 3'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_q;
  logic                   p_q;
  logic                   arm;
  logic [2:0]             fill_q;
  logic                   tick_edge;
  logic                   load_ok;
  logic                   at_max;
  logic                   at_zero;

  assign s_q       = sync_q[SYNC_STAGES-1];
  assign tick_edge = s_q & ~p_q & arm;
  assign at_max    = (tens == MAX_TENS) && (ones == MAX_ONES);
  assign at_zero   = (tens == 4'd0) && (ones == 4'd0);
  assign load_ok   = (ld_tens <= 4'd9) && (ld_ones <= 4'd9) &&
                     (({4'd0, ld_tens} * 8'd10 + {4'd0, ld_ones}) < MOD8);

  // s_q only reflects real tick_src samples once the synchroniser has refilled after reset
  // (fill_q == FILL_DONE); arming before that would count a tap already high at release.
  always_ff @(posedge clk) begin
    if (RESET) begin
      sync_q <= '0;
      p_q    <= 1'b0;
      arm    <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_src};
      p_q    <= s_q;
      if (fill_q != FILL_DONE) fill_q <= fill_q + 3'd1;
      if ((fill_q == FILL_DONE) && !s_q) arm <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      tens     <= '0;
      ones     <= '0;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        tens <= '0;
        ones <= '0;
      end else if (load) begin
        if (load_ok) begin
          tens <= ld_tens;
          ones <= ld_ones;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick_edge && en) begin
        if (up) begin
          if (at_max) begin
            tens  <= '0;
            ones  <= '0;
            carry <= 1'b1;
          end else if (ones == 4'd9) begin
            ones <= '0;
            tens <= tens + 4'd1;
          end else begin
            ones <= ones + 4'd1;
          end
        end else begin
          if (at_zero) begin
            tens  <= MAX_TENS;
            ones  <= MAX_ONES;
            carry <= 1'b1;
          end else if (ones == 4'd0) begin
            ones <= 4'd9;
            tens <= tens - 4'd1;
          end else begin
            ones <= ones - 4'd1;
          end
        end
      end
    end
  end

`ifdef COUNTER60_SEG7_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b0000000;
    case (d)
      4'd0: s = 7'b0111111;
      4'd1: s = 7'b0000110;
      4'd2: s = 7'b1011011;
      4'd3: s = 7'b1001111;
      4'd4: s = 7'b1100110;
      4'd5: s = 7'b1101101;
      4'd6: s = 7'b1111101;
      4'd7: s = 7'b0000111;
      4'd8: s = 7'b1111111;
      4'd9: s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (RESET) begin
      seg_tens <= 7'b0111111;
      seg_ones <= 7'b0111111;
    end else begin
      seg_tens <= seg7(tens);
      seg_ones <= seg7(ones);
    end
  end
`endif

endmodule

// File: doc/counter60_bcd.md
Name: counter60_bcd

Overview:
- Downstream consumer of the clock-divider tap bus.
- Takes one slow divider tap (for example, a ~1 Hz bit of the divider output) and synchronises it.
- Converts each rising edge of that tap into a single-cycle tick.
- Counts ticks in two-digit BCD modulo MODULUS, giving the seconds/minutes stage of the clock, with a one-cycle carry pulse to cascade the next stage.
- Supports up/down counting, synchronous clear and a parallel BCD load for time setting.

Parameters:
- MODULUS, 60, count range 0..MODULUS-1; legal values 2..99.
- SYNC_STAGES, 2, flip-flops in the tick_src synchroniser; legal values 2..4.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- tick_src  in  1  divider tap; may be asynchronous to clk and slow.
- en  in  1  count enable; ticks seen while low are discarded.
- up  in  1  1 = count up, 0 = count down.
- clr  in  1  synchronous clear to 00.
- load  in  1  load ld_tens:ld_ones.
- ld_tens  in  4  BCD tens value for load.
- ld_ones  in  4  BCD ones value for load.
- tens  out  4  BCD tens digit, registered.
- ones  out  4  BCD ones digit, registered.
- carry  out  1  one-cycle pulse on wrap (either direction), registered.
- load_err  out  1  one-cycle pulse when a load is rejected, registered.

Behaviour:
- Interface: one clock `clk`; reset `RESET` is synchronous and active-high.
- Reset values:
  - tens=0, ones=0, carry=0, load_err=0.
  - Synchroniser and edge-detect registers = 0.
  - arm=0.
- Synchroniser: tick_src passes through SYNC_STAGES flops to give s_q; the previous value is held in p_q.
- Edge detect:
  - edge = s_q & ~p_q & arm.
  - arm is set on the first cycle s_q==0 after reset. A tick_src that is already high at reset release is therefore never counted.
- Latency: with SYNC_STAGES=2, the count changes on the 3rd rising clk edge after tick_src is first sampled high.
- Priority per cycle, highest first:
  1. RESET.
  2. clr: tens:ones <= 00; carry=0.
  3. load: see load rules below.
  4. edge & en: count.
  5. Otherwise hold.
- Load rules:
  - Accepted only if ld_ones<=9, ld_tens<=9, and 10*ld_tens+ld_ones < MODULUS.
  - If rejected: count is unchanged and load_err pulses for 1 cycle.
- Dropped ticks: an edge that coincides with clr or load, or arrives while en=0, is dropped. It is not queued.
- Up count:
  - ones==9 gives ones=0 and tens+1.
  - At value MODULUS-1 the counter goes to 00 and carry=1 for exactly that one cycle.
- Down count:
  - ones==0 gives ones=9 and tens-1.
  - At 00 the counter goes to MODULUS-1 (BCD) and carry=1 for one cycle (borrow).
- Outputs never hold a non-BCD digit or a value >= MODULUS.
- carry and load_err are 0 on every cycle that does not produce them.
- Minimum spacing: one tick per 2*SYNC_STAGES+2 clk cycles of tick_src period. Faster input is out of scope.
- RESET asserted mid-count returns to the reset state on the next edge; any pending edge is lost.

Optional Feature:
- Macro: COUNTER60_SEG7_EN.
- When defined:
  - Adds outputs seg_tens[6:0] and seg_ones[6:0], active-high segments in gfedcba order.
  - Both are registered decodes of tens/ones, so they lag the digits by 1 cycle.
  - Reset value is the pattern for "0", 7'b0111111.
- When undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then 60 tick_src pulses with en=1, up=1 → sequence 00..59 then 00. carry is high for 1 cycle on the 59→00 transition only; each digit changes 3 clk cycles after tick_src rises.
2. load 5:9 with up=0, then 60 ticks → 58,57,..,00,59. carry pulses on 00→59; load 6:0 → load_err=1 for 1 cycle, value unchanged; load 0:A → load_err pulse.
3. tick_src held high through RESET release → no count. After tick_src falls and rises again → 01.
4. Edge coincident with clr at value 37 → 00, not 01. Edge with en=0 → value held. Edge coincident with an accepted load 2:2 → 22.
5. RESET asserted while at 45 during a tick → 00 next cycle, carry=0. MODULUS=24 instance: 23 + tick → 00 with carry.
6. With COUNTER60_SEG7_EN: value 7 → seg_ones=7'b0000111 one cycle after ones=7; after reset both seg outputs = 7'b0111111.
